base_arb_rrmux: RTL and testbench

Round-robin arbiter and multiplexer that shares one valid/ready output channel among `ways` requesters. Multi-beat transfers are locked until their end beat. The output passes through one full-throughput register stage. It sits in the base library between per-engine command or data queues and any single shared downstream resource, such as a DMA command port or a response bus.

---
 rtl/base_arb_rrmux_pkg.sv | 20 ++
 rtl/base_arb_rrpri.sv | 34 +++
 rtl/base_arb_rrmux.sv | 126 ++++++++++++
 tb/tb_base_arb_rrmux.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/base_arb_rrmux_pkg.sv
// Shared definitions for the round-robin arbiter/mux: lock FSM encoding and
// the index-width helper used to size the priority pointer and grant index.
package base_arb_rrmux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Bits needed to hold an index in 0..n-1, never less than one.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((33'd1 << r) < 33'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/base_arb_rrpri.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping,
// found by scanning the request vector laid out twice end to end.
module base_arb_rrpri
    import base_arb_rrmux_pkg::*;
#(
    parameter int unsigned ways = 4,
    parameter int unsigned iw   = 2
) (
    input  logic [0:ways-1] req,
    input  logic [iw-1:0]   ptr,
    output logic [0:ways-1] gnt,
    output logic [iw-1:0]   idx
);

    logic [0:2*ways-1] dbl;

    assign dbl = {req, req};

    // Only the ways-long window starting at ptr is eligible; first hit wins.
    always_comb begin
        logic found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < 2 * ways; j++) begin
            if (!found && (j >= 32'(ptr)) && (j < 32'(ptr) + ways) && dbl[j]) begin
                found           = 1'b1;
                gnt[j % ways]   = 1'b1;
                idx             = iw'(j % ways);
            end
        end
    end

endmodule

// File: rtl/base_arb_rrmux.sv
// Round-robin arbiter and mux onto one registered valid/ready channel; a
// multi-beat transfer holds the grant until its end beat is accepted.
module base_arb_rrmux
    import base_arb_rrmux_pkg::*;
#(
    parameter int unsigned ways  = 4,
    parameter int unsigned width = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ways-1]       i_v,
    output logic [0:ways-1]       i_r,
    input  logic [0:ways*width-1] i_d,
    input  logic [0:ways-1]       i_e,
    output logic                  o_v,
    input  logic                  o_r,
    output logic [0:width-1]      o_d,
    output logic                  o_e,
    output logic [0:ways-1]       o_sel
);

    localparam int unsigned   iw   = clog2(ways);
    localparam logic [iw-1:0] last = iw'(ways - 1);

    arb_state_t       state, state_nx;
    logic [iw-1:0]    ptr, ptr_nx;
    logic [iw-1:0]    lck, lck_nx;
    logic [0:ways-1]  rr_gnt;
    logic [iw-1:0]    rr_idx;
    logic [0:ways-1]  gnt;
    logic [iw-1:0]    widx;
    logic [iw-1:0]    widx_inc;
    logic [0:ways-1]  win_sel;
    logic [0:width-1] win_d;
    logic             win_e;
    logic             ld;
    logic             acc;

    base_arb_rrpri #(
        .ways (ways),
        .iw   (iw)
    ) u_pri (
        .req (i_v),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    assign ld       = ~o_v | o_r;
    assign widx     = (state == LOCK) ? lck : rr_idx;
    assign widx_inc = (widx == last) ? '0 : widx + iw'(1);

    // Decode the current winner into its one-hot select, payload and end flag.
    always_comb begin
        win_sel = '0;
        win_d   = '0;
        win_e   = 1'b0;
        for (int unsigned k = 0; k < ways; k++) begin
            if (iw'(k) == widx) begin
                win_sel[k] = 1'b1;
                win_d      = i_d[k*width +: width];
                win_e      = i_e[k];
            end
        end
    end

    // While idle an empty request vector must yield no grant, so use the scan result.
    assign gnt = (state == LOCK) ? win_sel : rr_gnt;
    assign i_r = gnt & {ways{ld}};
    assign acc = |(i_v & i_r);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        lck_nx   = lck;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (win_e) begin
                        ptr_nx = widx_inc;
                    end else begin
                        state_nx = LOCK;
                        lck_nx   = widx;
                    end
                end
            end
            LOCK: begin
                if (acc && win_e) begin
                    state_nx = IDLE;
                    ptr_nx   = widx_inc;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            lck   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            lck   <= lck_nx;
        end
    end

    // Output stage loads on accept, empties when drained, otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_v   <= 1'b0;
            o_d   <= '0;
            o_e   <= 1'b0;
            o_sel <= '0;
        end else if (acc) begin
            o_v   <= 1'b1;
            o_d   <= win_d;
            o_e   <= win_e;
            o_sel <= win_sel;
        end else if (o_r) begin
            o_v   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_base_arb_rrmux.sv
// Bench for base_arb_rrmux: per-cycle comparison against a behavioural model
// plus directed scenarios with hand-derived expectations.
module tb_base_arb_rrmux;

    localparam int unsigned WAYS = 4;
    localparam int unsigned W    = 16;

    logic                clk   = 1'b0;
    logic                reset = 1'b1;
    logic [0:WAYS-1]     i_v   = '0;
    logic [0:WAYS-1]     i_e   = '0;
    logic [0:WAYS-1]     i_r;
    logic [0:WAYS*W-1]   i_d   = '0;
    logic                o_v;
    logic                o_r   = 1'b0;
    logic [0:W-1]        o_d;
    logic                o_e;
    logic [0:WAYS-1]     o_sel;

    int checks = 0;
    int errors = 0;

    int              m_ptr  = 0;
    bit              m_lock = 1'b0;
    int              m_li   = 0;
    bit              m_ov   = 1'b0;
    bit              m_oe   = 1'b0;
    logic [0:W-1]    m_od   = '0;
    logic [0:WAYS-1] m_os   = '0;

    int           obs_i[$];
    logic [0:W-1] obs_d[$];

    base_arb_rrmux #(
        .ways  (WAYS),
        .width (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_r   (i_r),
        .i_d   (i_d),
        .i_e   (i_e),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_d   (o_d),
        .o_e   (o_e),
        .o_sel (o_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [0:WAYS-1] s);
        int r;
        int c;
        r = -1;
        c = 0;
        for (int k = 0; k < int'(WAYS); k++) begin
            if (s[k]) begin
                r = k;
                c++;
            end
        end
        return (c == 1) ? r : -1;
    endfunction

    task automatic put(input int k, input logic [0:W-1] d);
        i_d[k*W +: W] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_i.delete();
        obs_d.delete();
    endtask

    // Reference model: rotating-priority pick, lock on non-end beats, one-entry output slot.
    always @(negedge clk or posedge reset) begin : model
        int              w;
        bit              ld;
        logic [0:WAYS-1] er;
        if (reset) begin
            m_ptr  = 0;
            m_lock = 1'b0;
            m_li   = 0;
            m_ov   = 1'b0;
            m_oe   = 1'b0;
            m_od   = '0;
            m_os   = '0;
        end else begin
            ld = !m_ov || o_r;
            w  = -1;
            if (m_lock) begin
                w = m_li;
            end else begin
                for (int n = 0; n < int'(WAYS); n++) begin
                    if (w < 0 && i_v[(m_ptr + n) % int'(WAYS)]) w = (m_ptr + n) % int'(WAYS);
                end
            end
            er = '0;
            if (w >= 0 && ld) er[w] = 1'b1;
            chk("i_r", 64'(i_r), 64'(er));
            chk("o_v", 64'(o_v), 64'(m_ov));
            chk("o_e", 64'(o_e), 64'(m_oe));
            chk("o_sel", 64'(o_sel), 64'(m_os));
            chk("o_d", 64'(o_d), 64'(m_od));
            if (o_v && o_r) begin
                obs_i.push_back(idx_of(o_sel));
                obs_d.push_back(o_d);
            end
            if (w >= 0 && ld && i_v[w]) begin
                m_ov    = 1'b1;
                m_od    = i_d[w*W +: W];
                m_oe    = i_e[w];
                m_os    = '0;
                m_os[w] = 1'b1;
                if (i_e[w]) begin
                    m_lock = 1'b0;
                    m_ptr  = (w + 1) % int'(WAYS);
                end else begin
                    m_lock = 1'b1;
                    m_li   = w;
                end
            end else if (o_r) begin
                m_ov = 1'b0;
            end
        end
    end

    initial begin
        // reset and idle
        repeat (2) step();
        chk("rst_o_v", 64'(o_v), 64'd0);
        chk("rst_o_e", 64'(o_e), 64'd0);
        chk("rst_o_sel", 64'(o_sel), 64'd0);
        chk("rst_o_d", 64'(o_d), 64'd0);
        reset = 1'b0;
        repeat (3) begin
            step();
            chk("idle_i_r", 64'(i_r), 64'd0);
        end

        // fairness: all requesters, single beats
        clear_obs();
        i_v = '1;
        i_e = '1;
        o_r = 1'b1;
        for (int k = 0; k < int'(WAYS); k++) put(k, W'(16'h1000 + k));
        repeat (8) step();
        i_v = '0;
        repeat (2) step();
        chk("fair_count", 64'(obs_i.size()), 64'd8);
        for (int n = 0; n < 8 && n < obs_i.size(); n++) begin
            chk("fair_order", 64'(obs_i[n]), 64'(n % 4));
            chk("fair_data", 64'(obs_d[n]), 64'(16'h1000 + (n % 4)));
        end

        // lock on requester 2 with 0 and 3 competing
        clear_obs();
        i_e = '0;
        i_v = 4'b0010;
        put(2, 16'hD000);
        step();
        i_v = 4'b1011;
        i_e = 4'b1001;
        put(2, 16'hD001);
        put(0, 16'h0A00);
        put(3, 16'h3A00);
        #1;
        chk("lock_i_r", 64'(i_r), 64'(4'b0010));
        step();
        i_e = 4'b1011;
        put(2, 16'hD002);
        step();
        i_v = 4'b1001;
        repeat (2) step();
        i_v = '0;
        repeat (2) step();
        chk("lock_count", 64'(obs_i.size()), 64'd5);
        if (obs_i.size() == 5) begin
            chk("lock_s0", 64'(obs_i[0]), 64'd2);
            chk("lock_d0", 64'(obs_d[0]), 64'h0000_D000);
            chk("lock_s1", 64'(obs_i[1]), 64'd2);
            chk("lock_d1", 64'(obs_d[1]), 64'h0000_D001);
            chk("lock_s2", 64'(obs_i[2]), 64'd2);
            chk("lock_d2", 64'(obs_d[2]), 64'h0000_D002);
            chk("lock_s3", 64'(obs_i[3]), 64'd3);
            chk("lock_s4", 64'(obs_i[4]), 64'd0);
        end

        // backpressure with a held 0xA5 beat
        clear_obs();
        o_r = 1'b0;
        i_e = '1;
        i_v = 4'b1000;
        put(0, 16'h00A5);
        step();
        i_v = 4'b0100;
        put(1, 16'h005A);
        repeat (5) begin
            #1;
            chk("bp_o_d", 64'(o_d), 64'h00A5);
            chk("bp_o_v", 64'(o_v), 64'd1);
            chk("bp_i_r", 64'(i_r), 64'd0);
            step();
        end
        o_r = 1'b1;
        #1;
        chk("bp_release_i_r", 64'(i_r), 64'(4'b0100));
        step();
        chk("bp_next_d", 64'(o_d), 64'h005A);
        chk("bp_next_v", 64'(o_v), 64'd1);
        chk("bp_next_sel", 64'(o_sel), 64'(4'b0100));
        i_v = '0;
        step();
        chk("bp_drained", 64'(o_v), 64'd0);

        // bubble inside a lock held by requester 1
        clear_obs();
        i_e = '0;
        i_v = 4'b0100;
        put(1, 16'hB001);
        step();
        i_v = 4'b1000;
        i_e = 4'b1000;
        put(0, 16'h0B00);
        for (int b = 0; b < 3; b++) begin
            #1;
            chk("bub_i_r0", 64'(i_r[0]), 64'd0);
            if (b == 1) chk("bub_o_v", 64'(o_v), 64'd0);
            step();
        end
        i_v = 4'b1100;
        i_e = 4'b1100;
        put(1, 16'hB002);
        step();
        i_v = 4'b1000;
        step();
        i_v = '0;
        repeat (2) step();
        chk("bub_count", 64'(obs_i.size()), 64'd3);
        if (obs_i.size() == 3) begin
            chk("bub_s0", 64'(obs_i[0]), 64'd1);
            chk("bub_d1", 64'(obs_d[1]), 64'h0000_B002);
            chk("bub_s1", 64'(obs_i[1]), 64'd1);
            chk("bub_s2", 64'(obs_i[2]), 64'd0);
        end

        // reset in the middle of a locked transfer
        i_v = 4'b0010;
        i_e = '0;
        put(2, 16'hC000);
        step();
        put(2, 16'hC001);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_o_v", 64'(o_v), 64'd0);
        chk("mid_rst_o_e", 64'(o_e), 64'd0);
        chk("mid_rst_o_sel", 64'(o_sel), 64'd0);
        chk("mid_rst_o_d", 64'(o_d), 64'd0);
        step();
        reset = 1'b0;
        i_v = '1;
        i_e = '1;
        step();
        chk("post_rst_sel", 64'(o_sel), 64'(4'b1000));
        i_v = '0;
        repeat (2) step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            i_v = WAYS'($urandom);
            i_e = WAYS'($urandom);
            o_r = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < int'(WAYS); k++) put(k, W'($urandom));
            step();
        end
        i_v = '0;
        o_r = 1'b1;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
